ctrl_pipe: RTL and testbench
============================

CTRL_PIPE -- requirements
Module: ctrl_pipe

Interface
REQ-001 Parameter EN_M, default 1: 1 decodes the RV32M multiply/divide ops (opcode 0110011, funct7 0000001); 0 treats them as illegal.
REQ-002 Parameter ALUCTRL_W, default 5: width of ALUControl, widened from 4 to encode the M ops.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 opD  input  7  D-stage opcode.
REQ-006 funct3D  input  3  D-stage funct3.
REQ-007 funct7D  input  7  D-stage funct7.
REQ-008 funct12D  input  12  D-stage funct12.
REQ-009 FlushE  input  1  hazard unit bubble request for E.
REQ-010 ZeroE, ALUResultEb0  input  1 each  ALU flags for branch resolution.
REQ-011 md_done  input  1  multi-cycle mul/div unit result ready.
REQ-012 resume  input  1  debugger release from HALT.
REQ-013 ImmSrcD  output  3  combinational immediate select.
REQ-014 RegWriteE/M/W, MemWriteE/M  output  1 each  staged controls.
REQ-015 ResultSrcE/M/W  output  2  staged result select.
REQ-016 ALUSrcE  output  2  staged ALU operand select.
REQ-017 ALUControlE  output  ALUCTRL_W  staged ALU operation.
REQ-018 PCSrcE  output  1  branch/jump taken.
REQ-019 md_start  output  1  one-cycle start pulse to the mul/div unit.
REQ-020 stall_o  output  1  freezes F, D and E.
REQ-021 trap_valid  output  1  one-cycle trap pulse.
REQ-022 trap_cause  output  1  0 = ECALL, 1 = EBREAK, 1 also for an illegal instruction.
REQ-023 halted  output  1  core is in HALT.

Function
REQ-024 D-stage decode shall be combinational and follow RV32I (plus RV32M when EN_M=1), producing one control bundle: RegWrite, MemWrite, ResultSrc, ALUSrc, ALUControl, Branch, Jump, funct3, MulDiv, Ecall, Ebreak, Illegal, valid.
REQ-025 The D->E, E->M and M->W bundle registers shall each load on every rising edge unless held or bubbled; a bubble clears valid and all write enables.
REQ-026 PCSrcE = valid & (JumpE | BranchE & cond), where cond decodes funct3E: BEQ ZeroE, BNE !ZeroE, BLT/BLTU ALUResultEb0, BGE/BGEU !ALUResultEb0.
REQ-027 FSM states: RUN, MDWAIT, HALT.
REQ-028 RUN -> MDWAIT when a valid MulDivE is present: md_start pulses 1 cycle, the E register holds, and a bubble enters M.
REQ-029 In MDWAIT: stall_o=1 and md_start=0. On md_done, the E bundle advances to M in that same cycle and the FSM returns to RUN, so a second start does not fire for the same op.
REQ-030 RUN -> HALT when a valid EcallE, EbreakE or IllegalE is present: trap_valid pulses 1 cycle, trap_cause is set, and the E bundle is bubbled.
REQ-031 HALT: halted=1 and stall_o=1; resume high -> RUN on the next edge.
REQ-032 stall_o = (RUN & valid MulDivE) | MDWAIT & !md_done | HALT.
REQ-033 Hold beats flush: FlushE is ignored while stall_o=1. When stall_o=0 and FlushE=1, E is loaded with a bubble.
REQ-034 PCSrcE shall be forced to 0 while stall_o=1.
REQ-035 md_done outside MDWAIT shall be ignored.
REQ-036 resume outside HALT shall be ignored.

Reset
REQ-037 rst_n low shall force, asynchronously: FSM to RUN; all stage bundles to bubble; RegWrite*, MemWrite*, PCSrcE, md_start, stall_o, trap_valid, trap_cause and halted to 0; ResultSrc*, ALUSrcE and ALUControlE to 0.
REQ-038 Reset during MDWAIT or HALT shall abandon the operation and produce no trap_valid or md_start pulse on release.

Structure
REQ-039 Package ctrl_pkg shall hold the opcode constants, the ALU op enum (ALUCTRL_W bits), the state enum and a packed ctrl_bundle_t struct.
REQ-040 Decode shall sit in one sub-module, ctrl_dec (combinational); staging, the FSM and branch resolution stay in ctrl_pipe.

Verification
REQ-041 add x1,x2,x3 (0x003100B3) -> RegWriteE=1 one cycle later, RegWriteW=1 three cycles later, stall_o=0 throughout.
REQ-042 beq taken, ZeroE=1, funct3=000 -> PCSrcE=1. With FlushE=1 on the next edge, the following E bundle has valid=0.
REQ-043 mul (0x02208033), md_done 4 cycles after md_start -> exactly one md_start pulse, stall_o=1 for 4 cycles, RegWriteM=1 on the cycle after md_done.
REQ-044 ebreak (0x00100073) -> trap_valid=1 for one cycle with trap_cause=1, halted=1, stall_o=1. Pulsing resume returns to RUN with halted=0.
REQ-045 EN_M=0 with mul -> trap_valid and trap_cause=1, no md_start.
REQ-046 rst_n low mid-MDWAIT -> all outputs 0 immediately. After release: no md_start pulse, FSM in RUN.

Source files
------------

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the pipeline control slice.
//   - RV32 opcode / funct constants used by the decoder
//   - immediate and result select encodings
//   - ALU operation enum (base ops in 0..9, RV32M ops at 5'b10_fff)
//   - control FSM state enum
//   - ctrl_bundle_t, the per-instruction control word staged D->E->M->W
package ctrl_pkg;

    localparam int ALUOP_W = 5;

    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OP_IMM      = 7'b0010011;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_REG      = 7'b0110011;
    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_JAL      = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

    localparam logic [6:0]  F7_BASE    = 7'b0000000;
    localparam logic [6:0]  F7_ALT     = 7'b0100000;
    localparam logic [6:0]  F7_MULDIV  = 7'b0000001;
    localparam logic [11:0] F12_ECALL  = 12'h000;
    localparam logic [11:0] F12_EBREAK = 12'h001;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_J = 3'd3;
    localparam logic [2:0] IMM_U = 3'd4;

    localparam logic [1:0] RES_ALU = 2'd0;
    localparam logic [1:0] RES_MEM = 2'd1;
    localparam logic [1:0] RES_PC4 = 2'd2;
    localparam logic [1:0] RES_IMM = 2'd3;

    // ALUSrc[1] selects PC as operand A, ALUSrc[0] selects the immediate as B
    localparam logic [1:0] SRC_REG    = 2'b00;
    localparam logic [1:0] SRC_IMM    = 2'b01;
    localparam logic [1:0] SRC_PC_IMM = 2'b11;

    typedef enum logic [ALUOP_W-1:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_SLL    = 5'd2,
        ALU_SLT    = 5'd3,
        ALU_SLTU   = 5'd4,
        ALU_XOR    = 5'd5,
        ALU_SRL    = 5'd6,
        ALU_SRA    = 5'd7,
        ALU_OR     = 5'd8,
        ALU_AND    = 5'd9,
        ALU_MUL    = 5'd16,
        ALU_MULH   = 5'd17,
        ALU_MULHSU = 5'd18,
        ALU_MULHU  = 5'd19,
        ALU_DIV    = 5'd20,
        ALU_DIVU   = 5'd21,
        ALU_REM    = 5'd22,
        ALU_REMU   = 5'd23
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_MDWAIT = 2'd1,
        ST_HALT   = 2'd2
    } state_e;

    typedef struct packed {
        logic       valid;
        logic       regwrite;
        logic       memwrite;
        logic [1:0] resultsrc;
        logic [1:0] alusrc;
        alu_op_e    aluctrl;
        logic       branch;
        logic       jump;
        logic [2:0] funct3;
        logic       muldiv;
        logic       ecall;
        logic       ebreak;
        logic       illegal;
    } ctrl_bundle_t;

    localparam ctrl_bundle_t BUBBLE = '0;

    // Base integer op from funct3; alt selects SUB / SRA
    function automatic alu_op_e alu_from_funct3(input logic [2:0] f3, input logic alt);
        alu_op_e op;
        op = ALU_ADD;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/ctrl_dec.sv
// ctrl_dec: combinational D-stage decoder (RV32I, plus RV32M when EN_M=1).
//   op, funct3, funct7, funct12 : instruction fields of the D-stage word
//   imm_src                     : immediate format select
//   ctrl                        : control bundle for the instruction in D
// Unknown encodings (and M ops when EN_M=0) produce illegal=1 with no
// write enables, so they can only trap.
module ctrl_dec
    import ctrl_pkg::*;
#(
    parameter bit EN_M = 1'b1
) (
    input  logic [6:0]   op,
    input  logic [2:0]   funct3,
    input  logic [6:0]   funct7,
    input  logic [11:0]  funct12,
    output logic [2:0]   imm_src,
    output ctrl_bundle_t ctrl
);

    always_comb begin
        ctrl         = BUBBLE;
        ctrl.valid   = 1'b1;
        ctrl.funct3  = funct3;
        ctrl.aluctrl = ALU_ADD;
        imm_src      = IMM_I;
        case (op)
            OP_LOAD: begin
                if (funct3 == 3'b011 || funct3[2:1] == 2'b11) begin
                    ctrl.illegal = 1'b1;
                end else begin
                    ctrl.regwrite  = 1'b1;
                    ctrl.alusrc    = SRC_IMM;
                    ctrl.resultsrc = RES_MEM;
                end
            end
            OP_STORE: begin
                imm_src = IMM_S;
                if (funct3[2] || funct3 == 3'b011) begin
                    ctrl.illegal = 1'b1;
                end else begin
                    ctrl.memwrite = 1'b1;
                    ctrl.alusrc   = SRC_IMM;
                end
            end
            OP_REG: begin
                if (funct7 == F7_BASE ||
                    (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101))) begin
                    ctrl.regwrite = 1'b1;
                    ctrl.aluctrl  = alu_from_funct3(funct3, funct7[5]);
                end else if (EN_M && funct7 == F7_MULDIV) begin
                    ctrl.regwrite = 1'b1;
                    ctrl.muldiv   = 1'b1;
                    ctrl.aluctrl  = alu_op_e'({2'b10, funct3});
                end else begin
                    ctrl.illegal = 1'b1;
                end
            end
            OP_IMM: begin
                // only the shift-immediates constrain the upper bits
                if ((funct3 == 3'b001 && funct7 != F7_BASE) ||
                    (funct3 == 3'b101 && funct7 != F7_BASE && funct7 != F7_ALT)) begin
                    ctrl.illegal = 1'b1;
                end else begin
                    ctrl.regwrite = 1'b1;
                    ctrl.alusrc   = SRC_IMM;
                    ctrl.aluctrl  = alu_from_funct3(funct3, funct3 == 3'b101 && funct7[5]);
                end
            end
            OP_LUI: begin
                imm_src        = IMM_U;
                ctrl.regwrite  = 1'b1;
                ctrl.resultsrc = RES_IMM;
            end
            OP_AUIPC: begin
                imm_src       = IMM_U;
                ctrl.regwrite = 1'b1;
                ctrl.alusrc   = SRC_PC_IMM;
            end
            OP_BRANCH: begin
                imm_src = IMM_B;
                if (funct3[2:1] == 2'b01) begin
                    ctrl.illegal = 1'b1;
                end else begin
                    // EQ/NE look at Zero of a subtract, the rest at bit 0 of SLT(U)
                    ctrl.branch  = 1'b1;
                    ctrl.aluctrl = funct3[2] ? (funct3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
                end
            end
            OP_JAL: begin
                imm_src        = IMM_J;
                ctrl.regwrite  = 1'b1;
                ctrl.jump      = 1'b1;
                ctrl.resultsrc = RES_PC4;
            end
            OP_JALR: begin
                if (funct3 != 3'b000) begin
                    ctrl.illegal = 1'b1;
                end else begin
                    ctrl.regwrite  = 1'b1;
                    ctrl.jump      = 1'b1;
                    ctrl.alusrc    = SRC_IMM;
                    ctrl.resultsrc = RES_PC4;
                end
            end
            OP_MISC_MEM: begin
                // FENCE is a no-op in this in-order core
            end
            OP_SYSTEM: begin
                if (funct3 == 3'b000 && funct12 == F12_ECALL) begin
                    ctrl.ecall = 1'b1;
                end else if (funct3 == 3'b000 && funct12 == F12_EBREAK) begin
                    ctrl.ebreak = 1'b1;
                end else begin
                    ctrl.illegal = 1'b1;
                end
            end
            default: ctrl.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: pipeline control for a 5-stage RV32 core.
// Decodes the D-stage instruction (ctrl_dec), stages the control bundle
// through E, M and W, resolves branches in E, and runs a RUN/MDWAIT/HALT
// FSM for the multi-cycle mul/div unit and for traps.
//   clk, rst_n            : clock, asynchronous active-low reset
//   opD/funct3D/funct7D/funct12D : D-stage instruction fields
//   FlushE                : bubble request for E from the hazard unit
//   ZeroE, ALUResultEb0   : ALU flags for branch resolution
//   md_done, resume       : mul/div completion, debugger release from HALT
//   ImmSrcD               : immediate select (combinational)
//   RegWrite*/MemWrite*/ResultSrc*/ALUSrcE/ALUControlE : staged controls
//   PCSrcE                : branch/jump taken
//   md_start              : one-cycle start to the mul/div unit
//   stall_o               : freezes F, D and E
//   trap_valid/trap_cause : one-cycle trap pulse, cause 0=ECALL 1=EBREAK/illegal
//   halted                : core is in HALT
module ctrl_pipe
    import ctrl_pkg::*;
#(
    parameter bit EN_M      = 1'b1,
    parameter int ALUCTRL_W = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [6:0]           opD,
    input  logic [2:0]           funct3D,
    input  logic [6:0]           funct7D,
    input  logic [11:0]          funct12D,
    input  logic                 FlushE,
    input  logic                 ZeroE,
    input  logic                 ALUResultEb0,
    input  logic                 md_done,
    input  logic                 resume,
    output logic [2:0]           ImmSrcD,
    output logic                 RegWriteE,
    output logic                 RegWriteM,
    output logic                 RegWriteW,
    output logic                 MemWriteE,
    output logic                 MemWriteM,
    output logic [1:0]           ResultSrcE,
    output logic [1:0]           ResultSrcM,
    output logic [1:0]           ResultSrcW,
    output logic [1:0]           ALUSrcE,
    output logic [ALUCTRL_W-1:0] ALUControlE,
    output logic                 PCSrcE,
    output logic                 md_start,
    output logic                 stall_o,
    output logic                 trap_valid,
    output logic                 trap_cause,
    output logic                 halted
);

    ctrl_bundle_t dec_d;
    ctrl_bundle_t bun_p0;
    ctrl_bundle_t bun_p1;
    ctrl_bundle_t bun_p2;
    state_e       state;
    logic         vld_p0;
    logic         md_e;
    logic         trap_e;
    logic         cond_e;
    logic         unused_w;

    ctrl_dec #(.EN_M(EN_M)) u_dec (
        .op      (opD),
        .funct3  (funct3D),
        .funct7  (funct7D),
        .funct12 (funct12D),
        .imm_src (ImmSrcD),
        .ctrl    (dec_d)
    );

    assign vld_p0 = bun_p0.valid;
    assign md_e   = vld_p0 && bun_p0.muldiv;
    assign trap_e = vld_p0 && (bun_p0.ecall || bun_p0.ebreak || bun_p0.illegal);

    assign stall_o = (state == ST_RUN && md_e) ||
                     (state == ST_MDWAIT && !md_done) ||
                     (state == ST_HALT);

    // Start and trap fire only from RUN, so an op held in E through MDWAIT
    // cannot restart the unit, and a reset release never produces a pulse.
    assign md_start   = (state == ST_RUN) && md_e;
    assign trap_valid = (state == ST_RUN) && trap_e;
    assign trap_cause = trap_valid && (bun_p0.ebreak || bun_p0.illegal);
    assign halted     = (state == ST_HALT);

    always_comb begin
        cond_e = 1'b0;
        case (bun_p0.funct3)
            3'b000:          cond_e = ZeroE;
            3'b001:          cond_e = !ZeroE;
            3'b100, 3'b110:  cond_e = ALUResultEb0;
            3'b101, 3'b111:  cond_e = !ALUResultEb0;
            default:         cond_e = 1'b0;
        endcase
    end

    assign PCSrcE = !stall_o && vld_p0 && (bun_p0.jump || (bun_p0.branch && cond_e));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
        end else begin
            case (state)
                ST_RUN: begin
                    if (md_e)        state <= ST_MDWAIT;
                    else if (trap_e) state <= ST_HALT;
                end
                ST_MDWAIT: if (md_done) state <= ST_RUN;
                ST_HALT:   if (resume)  state <= ST_RUN;
                default:   state <= ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bun_p0 <= BUBBLE;
            bun_p1 <= BUBBLE;
            bun_p2 <= BUBBLE;
        end else begin
            // D -> E: a hold wins over FlushE; a trapping op is dropped
            if (!stall_o) begin
                bun_p0 <= (FlushE || trap_valid) ? BUBBLE : dec_d;
            end
            // E -> M: bubble while E is held or trapping
            bun_p1 <= (stall_o || trap_valid) ? BUBBLE : bun_p0;
            // M -> W
            bun_p2 <= bun_p1;
        end
    end

    assign RegWriteE   = bun_p0.regwrite;
    assign MemWriteE   = bun_p0.memwrite;
    assign ResultSrcE  = bun_p0.resultsrc;
    assign ALUSrcE     = bun_p0.alusrc;
    assign ALUControlE = ALUCTRL_W'(bun_p0.aluctrl);
    assign RegWriteM   = bun_p1.regwrite;
    assign MemWriteM   = bun_p1.memwrite;
    assign ResultSrcM  = bun_p1.resultsrc;
    assign RegWriteW   = bun_p2.regwrite;
    assign ResultSrcW  = bun_p2.resultsrc;

    // W only needs the write enable and result select
    assign unused_w = ^bun_p2;

endmodule

// File: tb/tb_ctrl_pipe.sv
module tb_ctrl_pipe;

    logic        clk;
    logic        rst_n;
    logic [6:0]  opD;
    logic [2:0]  funct3D;
    logic [6:0]  funct7D;
    logic [11:0] funct12D;
    logic        FlushE, ZeroE, ALUResultEb0, md_done, resume;

    logic [2:0] ImmSrcD, ImmSrcD0;
    logic       RegWriteE, RegWriteM, RegWriteW, MemWriteE, MemWriteM;
    logic       RegWriteE0, RegWriteM0, RegWriteW0, MemWriteE0, MemWriteM0;
    logic [1:0] ResultSrcE, ResultSrcM, ResultSrcW, ALUSrcE;
    logic [1:0] ResultSrcE0, ResultSrcM0, ResultSrcW0, ALUSrcE0;
    logic [4:0] ALUControlE, ALUControlE0;
    logic       PCSrcE, md_start, stall_o, trap_valid, trap_cause, halted;
    logic       PCSrcE0, md_start0, stall_o0, trap_valid0, trap_cause0, halted0;

    int checks = 0;
    int failures = 0;

    localparam logic [31:0] I_ADD    = 32'h003100B3;
    localparam logic [31:0] I_MUL    = 32'h02208033;
    localparam logic [31:0] I_LW     = 32'h00012083;
    localparam logic [31:0] I_SW     = 32'h00112023;
    localparam logic [31:0] I_BEQ    = 32'h00000063;
    localparam logic [31:0] I_FENCE  = 32'h0000000F;
    localparam logic [31:0] I_ECALL  = 32'h00000073;
    localparam logic [31:0] I_EBREAK = 32'h00100073;
    localparam logic [31:0] I_BAD    = 32'h00000000;

    localparam logic [31:0] BR_INS [8] = '{32'h00000063, 32'h00000063, 32'h00001063,
                                           32'h00004063, 32'h00005063, 32'h00006063,
                                           32'h00007063, 32'h0000006F};
    localparam logic [7:0] BR_Z   = 8'b0000_0001;
    localparam logic [7:0] BR_B   = 8'b0001_1000;
    localparam logic [7:0] BR_EXP = 8'b1100_1101;

    localparam logic [31:0] TR_INS [3] = '{32'h00000073, 32'h00100073, 32'h00000000};
    localparam logic [2:0]  TR_CAUSE = 3'b110;

    ctrl_pipe #(.EN_M(1'b1), .ALUCTRL_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .opD(opD), .funct3D(funct3D), .funct7D(funct7D),
        .funct12D(funct12D), .FlushE(FlushE), .ZeroE(ZeroE), .ALUResultEb0(ALUResultEb0),
        .md_done(md_done), .resume(resume), .ImmSrcD(ImmSrcD),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemWriteE(MemWriteE), .MemWriteM(MemWriteM),
        .ResultSrcE(ResultSrcE), .ResultSrcM(ResultSrcM), .ResultSrcW(ResultSrcW),
        .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE), .PCSrcE(PCSrcE),
        .md_start(md_start), .stall_o(stall_o), .trap_valid(trap_valid),
        .trap_cause(trap_cause), .halted(halted)
    );

    ctrl_pipe #(.EN_M(1'b0), .ALUCTRL_W(5)) dut0 (
        .clk(clk), .rst_n(rst_n), .opD(opD), .funct3D(funct3D), .funct7D(funct7D),
        .funct12D(funct12D), .FlushE(FlushE), .ZeroE(ZeroE), .ALUResultEb0(ALUResultEb0),
        .md_done(md_done), .resume(resume), .ImmSrcD(ImmSrcD0),
        .RegWriteE(RegWriteE0), .RegWriteM(RegWriteM0), .RegWriteW(RegWriteW0),
        .MemWriteE(MemWriteE0), .MemWriteM(MemWriteM0),
        .ResultSrcE(ResultSrcE0), .ResultSrcM(ResultSrcM0), .ResultSrcW(ResultSrcW0),
        .ALUSrcE(ALUSrcE0), .ALUControlE(ALUControlE0), .PCSrcE(PCSrcE0),
        .md_start(md_start0), .stall_o(stall_o0), .trap_valid(trap_valid0),
        .trap_cause(trap_cause0), .halted(halted0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_instr(input logic [31:0] ins);
        opD      = ins[6:0];
        funct3D  = ins[14:12];
        funct7D  = ins[31:25];
        funct12D = ins[31:20];
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [10:0] ctl;
        logic [12:0] dat;
        repeat (2) @(posedge clk);
        @(negedge clk);
        ctl = {RegWriteE, RegWriteM, RegWriteW, MemWriteE, MemWriteM, PCSrcE,
               md_start, stall_o, trap_valid, trap_cause, halted};
        dat = {ResultSrcE, ResultSrcM, ResultSrcW, ALUSrcE, ALUControlE};
        checks++;
        if (ctl !== 11'd0) begin failures++; $display("FAIL reset_ctl got=%b exp=0", ctl); end
        checks++;
        if (dat !== 13'd0) begin failures++; $display("FAIL reset_data got=%b exp=0", dat); end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_add;
        int bad;
        bad = 0;
        set_instr(I_ADD);
        tick();
        set_instr(I_FENCE);
        @(negedge clk);
        bad += int'(stall_o);
        checks++;
        if ({RegWriteE, ALUSrcE, ALUControlE} !== {1'b1, 2'b00, 5'd0}) begin
            failures++;
            $display("FAIL add_e got=%b exp=1_00_00000", {RegWriteE, ALUSrcE, ALUControlE});
        end
        tick();
        @(negedge clk);
        bad += int'(stall_o);
        checks++;
        if (RegWriteM !== 1'b1) begin failures++; $display("FAIL add_m got=%b exp=1", RegWriteM); end
        tick();
        @(negedge clk);
        bad += int'(stall_o);
        checks++;
        if ({RegWriteW, ResultSrcW} !== 3'b100) begin
            failures++; $display("FAIL add_w got=%b exp=100", {RegWriteW, ResultSrcW});
        end
        checks++;
        if (bad !== 0) begin failures++; $display("FAIL add_stall got=%0d exp=0", bad); end
    endtask

    task automatic test_load_store;
        set_instr(I_LW);
        #1;
        checks++;
        if (ImmSrcD !== 3'd0) begin failures++; $display("FAIL lw_imm got=%0d exp=0", ImmSrcD); end
        tick();
        set_instr(I_SW);
        #1;
        checks++;
        if (ImmSrcD !== 3'd1) begin failures++; $display("FAIL sw_imm got=%0d exp=1", ImmSrcD); end
        @(negedge clk);
        checks++;
        if ({RegWriteE, ResultSrcE, ALUSrcE} !== 5'b1_01_01) begin
            failures++; $display("FAIL lw_e got=%b exp=10101", {RegWriteE, ResultSrcE, ALUSrcE});
        end
        tick();
        set_instr(I_FENCE);
        @(negedge clk);
        checks++;
        if ({MemWriteE, RegWriteE, ALUSrcE} !== 4'b1001) begin
            failures++; $display("FAIL sw_e got=%b exp=1001", {MemWriteE, RegWriteE, ALUSrcE});
        end
        tick();
        @(negedge clk);
        checks++;
        if ({MemWriteM, RegWriteM} !== 2'b10) begin
            failures++; $display("FAIL sw_m got=%b exp=10", {MemWriteM, RegWriteM});
        end
    endtask

    task automatic test_branch;
        for (int i = 0; i < 8; i++) begin
            set_instr(BR_INS[i]);
            ZeroE = BR_Z[i];
            ALUResultEb0 = BR_B[i];
            tick();
            @(negedge clk);
            checks++;
            if (PCSrcE !== BR_EXP[i]) begin
                failures++; $display("FAIL branch_%0d got=%b exp=%b", i, PCSrcE, BR_EXP[i]);
            end
        end
        set_instr(I_BEQ);
        ZeroE = 1'b1;
        ALUResultEb0 = 1'b0;
        #1;
        checks++;
        if (ImmSrcD !== 3'd2) begin failures++; $display("FAIL beq_imm got=%0d exp=2", ImmSrcD); end
        tick();
        @(negedge clk);
        checks++;
        if (PCSrcE !== 1'b1) begin failures++; $display("FAIL beq_taken got=%b exp=1", PCSrcE); end
        FlushE = 1'b1;
        tick();
        FlushE = 1'b0;
        @(negedge clk);
        checks++;
        if (PCSrcE !== 1'b0) begin failures++; $display("FAIL flush_bubble got=%b exp=0", PCSrcE); end
        tick();
        @(negedge clk);
        checks++;
        if (PCSrcE !== 1'b1) begin failures++; $display("FAIL beq_reload got=%b exp=1", PCSrcE); end
        set_instr(I_FENCE);
        ZeroE = 1'b0;
        tick();
    endtask

    task automatic test_mul;
        int starts, stalls, bad_m;
        starts = 0; stalls = 0; bad_m = 0;
        set_instr(I_MUL);
        tick();
        set_instr(I_FENCE);
        for (int k = 0; k < 8; k++) begin
            md_done = (k == 4) || (k == 6);
            FlushE  = (k == 2);
            @(negedge clk);
            starts += int'(md_start);
            stalls += int'(stall_o);
            if (k == 0) begin
                checks++;
                if (ALUControlE !== 5'd16) begin
                    failures++; $display("FAIL mul_aluctrl got=%0d exp=16", ALUControlE);
                end
            end
            if (k >= 1 && k <= 4) bad_m += int'(RegWriteM);
            if (k == 5) begin
                checks++;
                if (RegWriteM !== 1'b1) begin
                    failures++; $display("FAIL mul_regwrite_m got=%b exp=1", RegWriteM);
                end
            end
            tick();
        end
        md_done = 1'b0;
        FlushE = 1'b0;
        checks++;
        if (starts !== 1) begin failures++; $display("FAIL mul_starts got=%0d exp=1", starts); end
        checks++;
        if (stalls !== 4) begin failures++; $display("FAIL mul_stalls got=%0d exp=4", stalls); end
        checks++;
        if (bad_m !== 0) begin failures++; $display("FAIL mul_m_bubble got=%0d exp=0", bad_m); end
    endtask

    task automatic test_traps;
        resume = 1'b1;
        tick();
        resume = 1'b0;
        @(negedge clk);
        checks++;
        if ({halted, stall_o} !== 2'b00) begin
            failures++; $display("FAIL resume_in_run got=%b exp=00", {halted, stall_o});
        end
        for (int i = 0; i < 3; i++) begin
            set_instr(TR_INS[i]);
            tick();
            set_instr(I_FENCE);
            @(negedge clk);
            checks++;
            if ({trap_valid, trap_cause, halted} !== {1'b1, TR_CAUSE[i], 1'b0}) begin
                failures++;
                $display("FAIL trap_%0d got=%b exp=1%b0", i, {trap_valid, trap_cause, halted}, TR_CAUSE[i]);
            end
            tick();
            tick();
            @(negedge clk);
            checks++;
            if ({trap_valid, halted, stall_o} !== 3'b011) begin
                failures++; $display("FAIL halt_%0d got=%b exp=011", i, {trap_valid, halted, stall_o});
            end
            resume = 1'b1;
            tick();
            resume = 1'b0;
            @(negedge clk);
            checks++;
            if ({halted, stall_o, trap_valid} !== 3'b000) begin
                failures++; $display("FAIL resume_%0d got=%b exp=000", i, {halted, stall_o, trap_valid});
            end
        end
    endtask

    task automatic test_enm0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        set_instr(I_MUL);
        tick();
        set_instr(I_FENCE);
        @(negedge clk);
        checks++;
        if ({trap_valid0, trap_cause0, md_start0} !== 3'b110) begin
            failures++; $display("FAIL enm0_trap got=%b exp=110", {trap_valid0, trap_cause0, md_start0});
        end
        tick();
        @(negedge clk);
        checks++;
        if ({halted0, md_start0} !== 2'b10) begin
            failures++; $display("FAIL enm0_halt got=%b exp=10", {halted0, md_start0});
        end
    endtask

    task automatic test_reset_mdwait;
        logic [13:0] outs;
        int bad;
        bad = 0;
        checks++;
        if ({stall_o, md_start} !== 2'b10) begin
            failures++; $display("FAIL mdwait_entry got=%b exp=10", {stall_o, md_start});
        end
        #2;
        rst_n = 1'b0;
        #1;
        outs = {RegWriteE, RegWriteM, RegWriteW, MemWriteE, MemWriteM, PCSrcE,
                md_start, stall_o, trap_valid, trap_cause, halted, ImmSrcD};
        checks++;
        if (outs !== 14'd0) begin failures++; $display("FAIL async_reset got=%b exp=0", outs); end
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bad += int'(md_start) + int'(stall_o) + int'(halted) + int'(trap_valid);
            tick();
        end
        checks++;
        if (bad !== 0) begin failures++; $display("FAIL post_reset_quiet got=%0d exp=0", bad); end
        set_instr(I_ADD);
        tick();
        set_instr(I_FENCE);
        @(negedge clk);
        checks++;
        if ({RegWriteE, stall_o} !== 2'b10) begin
            failures++; $display("FAIL post_reset_run got=%b exp=10", {RegWriteE, stall_o});
        end
    endtask

    initial begin
        rst_n = 1'b0;
        FlushE = 1'b0;
        ZeroE = 1'b0;
        ALUResultEb0 = 1'b0;
        md_done = 1'b0;
        resume = 1'b0;
        set_instr(I_FENCE);
        test_reset();
        test_add();
        test_load_store();
        test_branch();
        test_mul();
        test_traps();
        test_enm0();
        test_reset_mdwait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
